// File: rtl/divider_8bit_pkg.sv
// ============================================================================
// Module      : divider_8bit_pkg
// Description : Shared widths, iteration count and FSM state encodings for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_8bit_pkg;

    // Datapath width of operands and results
    localparam int DATA_WIDTH = 8;

    // One quotient bit is produced per iteration
    localparam int DIV_ITER = 8;

    // Iteration counter width; it wraps from the last step back to zero
    localparam int CNT_W = 3;

    // Controller state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : divider_8bit_pkg

`default_nettype wire

// File: rtl/divider_8bit_if.sv
// ============================================================================
// Module      : divider_8bit_if
// Description : Start/done request bus between the control unit (master) and
//               the divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divider_8bit_if
    import divider_8bit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Control unit side: issues requests, observes status and results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : divider_8bit_if

`default_nettype wire

// File: rtl/divider_8bit_sub.sv
// ============================================================================
// Module      : subtractor_8bit
// Description : Combinational trial subtractor producing a difference and a
//               borrow flag (a < b). Shared with the ALU subtract path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor_8bit #(
    parameter int WIDTH = 9
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] diff,
    output logic                  borrow
);

    logic [WIDTH:0] w_full;

    // One extra bit on the left captures the borrow out of the MSB
    assign w_full = {1'b0, a} - {1'b0, b};
    assign diff   = w_full[WIDTH-1:0];
    assign borrow = w_full[WIDTH];

endmodule : subtractor_8bit

`default_nettype wire

// File: rtl/divider_8bit.sv
// ============================================================================
// Module      : divider_8bit
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, MSB first. Results are held until the next accepted
//               start; divide-by-zero completes in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_8bit
    import divider_8bit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  wire logic    clk,
    input  wire logic    rst,
    divider_8bit_if.slave bus
);

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(DIV_ITER - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] q_sh_q,   q_sh_d;     // dividend shifting out / quotient shifting in
    logic [WIDTH:0]   r_q,      r_d;        // partial remainder
    logic [WIDTH:0]   d_q,      d_d;        // zero-extended divisor
    logic [WIDTH-1:0] quot_q,   quot_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic             dbz_q,    dbz_d;

    logic [WIDTH:0]   w_trial_a;
    logic [WIDTH:0]   w_trial_diff;
    logic             w_trial_borrow;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH:0]   w_r_next;
    logic             w_unused;

    // The partial remainder always stays below the divisor, so its top bit
    // never feeds the next trial; only the low WIDTH bits are shifted up.
    assign w_trial_a = {r_q[WIDTH-1:0], q_sh_q[WIDTH-1]};
    assign w_unused  = r_q[WIDTH];

    subtractor_8bit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a      (w_trial_a),
        .b      (d_q),
        .diff   (w_trial_diff),
        .borrow (w_trial_borrow)
    );

    // Restoring step: keep the difference when it did not borrow
    assign w_q_next = {q_sh_q[WIDTH-2:0], ~w_trial_borrow};
    assign w_r_next = w_trial_borrow ? w_trial_a : w_trial_diff;

    // Next-state, datapath and result-register logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_sh_d  = q_sh_q;
        r_d     = r_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    q_sh_d  = bus.dividend;
                    r_d     = '0;
                    d_d     = {1'b0, bus.divisor};
                    count_d = '0;
                    dbz_d   = 1'b0;
                    if (bus.divisor == '0) begin
                        // Nothing to iterate: publish the flagged result now
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                q_sh_d  = w_q_next;
                r_d     = w_r_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == C_LAST_STEP) begin
                    // Results become visible only on entry to DONE
                    state_d = ST_DONE;
                    quot_d  = w_q_next;
                    rem_d   = w_r_next[WIDTH-1:0];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            q_sh_q  <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_sh_q  <= q_sh_d;
            r_q     <= r_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == ST_BUSY);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule : divider_8bit

`default_nettype wire

// File: tb/tb_divider_8bit.sv
// ============================================================================
// Module      : tb_divider_8bit
// Description : Self-checking bench for divider_8bit: directed and random
//               divisions against plain integer division, divide-by-zero,
//               ignored start while busy, back-to-back start, mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_8bit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Last result the bench expects to be held on the outputs
    logic [7:0] held_q;
    logic [7:0] held_r;

    divider_8bit_if bus ();

    divider_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request across a single rising edge; returns at the
    // negedge of the first cycle after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        held_q = 8'd0;
        held_r = 8'd0;
    endtask

    // Directed cases first, then random nonzero divisors
    task automatic test_divide;
        logic [7:0] a, b, eq, er;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0: begin a = 8'd200; b = 8'd7; end
                1: begin a = 8'd255; b = 8'd1; end
                2: begin a = 8'd5;   b = 8'd9; end
                3: begin a = 8'd255; b = 8'd255; end
                4: begin a = 8'd0;   b = 8'd13; end
                default: begin
                    a = 8'($urandom_range(0, 255));
                    b = (i % 3 == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom_range(1, 255));
                end
            endcase
            eq = 8'(int'(a) / int'(b));
            er = 8'(int'(a) % int'(b));
            launch(a, b);
            for (int c = 1; c <= 8; c++) begin
                n_checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
                    bus.quotient !== held_q || bus.remainder !== held_r) begin
                    n_fail++;
                    $display("FAIL busy_phase %0d/%0d cyc%0d: got busy=%b done=%b dbz=%b q=%0d r=%0d, want 1 0 0 q=%0d r=%0d",
                             a, b, c, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, held_q, held_r);
                end
                @(negedge clk);
            end
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.div_by_zero !== 1'b0 ||
                bus.quotient !== eq || bus.remainder !== er) begin
                n_fail++;
                $display("FAIL result %0d/%0d: got busy=%b done=%b dbz=%b q=%0d r=%0d, want 0 1 0 q=%0d r=%0d",
                         a, b, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, eq, er);
            end
            n_checks++;
            if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) || bus.remainder >= b) begin
                n_fail++;
                $display("FAIL invariant %0d/%0d: got q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
            end
            held_q = eq;
            held_r = er;
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== eq || bus.remainder !== er) begin
                n_fail++;
                $display("FAIL hold %0d/%0d: got done=%b busy=%b q=%0d r=%0d, want 0 0 q=%0d r=%0d",
                         a, b, bus.done, bus.busy, bus.quotient, bus.remainder, eq, er);
            end
        end
    endtask

    task automatic test_div_by_zero;
        launch(8'd37, 8'd0);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.div_by_zero !== 1'b1 ||
            bus.quotient !== 8'hFF || bus.remainder !== 8'd37) begin
            n_fail++;
            $display("FAIL dbz_result: got busy=%b done=%b dbz=%b q=%0d r=%0d, want 0 1 1 q=255 r=37",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b1 ||
                bus.quotient !== 8'hFF || bus.remainder !== 8'd37) begin
                n_fail++;
                $display("FAIL dbz_hold: got busy=%b done=%b dbz=%b q=%0d r=%0d, want 0 0 1 q=255 r=37",
                         bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
            end
        end
        held_q = 8'hFF;
        held_r = 8'd37;
        // Next accepted start clears the flag immediately
        launch(8'd50, 8'd5);
        n_checks++;
        if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 8'hFF) begin
            n_fail++;
            $display("FAIL dbz_clear: got dbz=%b busy=%b q=%0d, want 0 1 255",
                     bus.div_by_zero, bus.busy, bus.quotient);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL dbz_followup: got done=%b q=%0d r=%0d, want 1 10 0",
                     bus.done, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        held_q = 8'd10;
        held_r = 8'd0;
    endtask

    task automatic test_ignore_start_busy;
        int dones;
        dones = 0;
        launch(8'd200, 8'd7);
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) dones++;
            if (c == 9) begin
                n_checks++;
                if (bus.done !== 1'b1 || bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin
                    n_fail++;
                    $display("FAIL ignore_result: got done=%b q=%0d r=%0d, want 1 28 4",
                             bus.done, bus.quotient, bus.remainder);
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_checks++;
        if (dones != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_single_done: got %0d done pulses busy=%b, want 1 pulse busy=0", dones, bus.busy);
        end
        held_q = 8'd28;
        held_r = 8'd4;
    endtask

    task automatic test_back_to_back;
        launch(8'd200, 8'd7);
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want 1 28 4",
                     bus.done, bus.quotient, bus.remainder);
        end
        launch(8'd100, 8'd10);
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin
                n_fail++;
                $display("FAIL b2b_busy cyc%0d: got busy=%b done=%b q=%0d r=%0d, want 1 0 28 4",
                         c, bus.busy, bus.done, bus.quotient, bus.remainder);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b q=%0d r=%0d, want 1 10 0",
                     bus.done, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        held_q = 8'd10;
        held_r = 8'd0;
    endtask

    task automatic test_reset_mid_op;
        int dones;
        dones = 0;
        launch(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d active cycles after reset, want 0", dones);
        end
        launch(8'd200, 8'd7);
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 8'd28 || bus.remainder !== 8'd4 || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_recover: got done=%b q=%0d r=%0d dbz=%b, want 1 28 4 0",
                     bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
        @(negedge clk);
        test_reset();
        test_divide();
        test_div_by_zero();
        test_ignore_start_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_divider_8bit

`default_nettype wire
